// File: rtl/rca_pipe.sv
// Elastic ripple-carry add/sub: STAGES-deep, one WIDTH/STAGES-bit carry chunk per stage.
// Result valid STAGES cycles after presentation; per-stage ready chain gives 1 beat/cycle and collapses bubbles under stall.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[STAGES-1];

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    // RIN operand bits still unconsumed on entry; DW result bits finished on exit
    localparam int RIN = WIDTH - k * C;
    localparam int DW  = (k + 1) * C;

    logic [RIN-1:0] a_in;
    logic [RIN-1:0] b_in;
    logic           c_in;
    logic           v_in;
    logic [C:0]     add;
    logic [DW-1:0]  s_nx;
    logic [DW-1:0]  s_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign v_in = in_valid;
      assign s_nx = add[C-1:0];
    end else begin : g_src
      assign a_in = g_stg[k-1].g_fwd.a_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = vld[k-1];
      assign s_nx = {add[C-1:0], g_stg[k-1].s_q};
    end

    assign add    = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, c_in};
    assign rdy[k] = ~v_q | rdy[k+1];
    assign vld[k] = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= v_in;
        if (v_in) begin
          s_q <= s_nx;
          c_q <= add[C];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RIN-C-1:0] a_q;
      logic [RIN-C-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k] && v_in) begin
          a_q <= a_in[RIN-1:C];
          b_q <= b_in[RIN-1:C];
        end
      end
    end else begin : g_last
      logic ovf_q;
      // carry into the MSB is recovered from the MSB sum bit and its addends
      logic msb_cin;
      assign msb_cin = a_in[C-1] ^ b_in[C-1] ^ add[C-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (rdy[k] && v_in) begin
          ovf_q <= msb_cin ^ add[C];
        end
      end
    end
  end

  assign sum  = g_stg[STAGES-1].s_q;
  assign cout = g_stg[STAGES-1].c_q;
  assign ovf  = g_stg[STAGES-1].g_last.ovf_q;

endmodule
